mesm6_memarb: RTL
=================

MESM6_MEMARB -- requirements
Module: mesm6_memarb

Interface
REQ-001 SHALL provide parameter DBUS_PRIO, default 0; 0 = round-robin between requesters, 1 = dbus always wins on a tie.
REQ-002 SHALL provide parameter TIMEOUT, default 64; the number of cycles to wait for mem_done before aborting, legal range 2..255.
REQ-003 SHALL have ports, in this order:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ibus_rd  in  1  instruction fetch request, held until ibus_done.
- ibus_addr  in  15  fetch address.
- ibus_input  out  48  fetch data.
- ibus_done  out  1  one-cycle fetch completion.
- dbus_rd  in  1  data read request, held until dbus_done.
- dbus_wr  in  1  data write request, held until dbus_done.
- dbus_addr  in  15  data address.
- dbus_output  in  48  write data from core.
- dbus_input  out  48  read data to core.
- dbus_done  out  1  one-cycle data completion.
- mem_rd  out  1  shared memory read strobe.
- mem_wr  out  1  shared memory write strobe.
- mem_addr  out  15  shared memory address.
- mem_wdata  out  48  shared memory write data.
- mem_rdata  in  48  shared memory read data, valid while mem_done=1.
- mem_done  in  1  one-cycle memory completion.
- bus_err  out  1  one-cycle timeout pulse.
- err_addr  out  15  address of the last timed-out access.

Function
REQ-004 SHALL implement the FSM states IDLE, IBUS and DBUS; exactly one requester is granted at a time.
REQ-005 In IDLE with exactly one request pending, SHALL go to the matching state at the next edge; a dbus request is dbus_rd|dbus_wr.
REQ-006 In IDLE with both requests pending, SHALL choose as follows:
- DBUS_PRIO=1: dbus is granted.
- DBUS_PRIO=0: the side not granted last is granted; the last-grant register resets to IBUS, so dbus wins the first tie.
REQ-007 On the grant edge, SHALL register mem_addr, mem_wdata and the access kind; mem_rd/mem_wr SHALL be asserted from the cycle after the request was seen in IDLE (latency 1) until mem_done.
REQ-008 IBUS state SHALL drive mem_rd=1 and mem_wr=0; mem_wdata is don't-care.
REQ-009 DBUS state SHALL drive mem_wr=1 if dbus_wr was sampled at grant, else mem_rd=1; dbus_rd and dbus_wr both high SHALL be treated as a write.
REQ-010 Never SHALL mem_rd and mem_wr be asserted together, nor either one in IDLE.
REQ-011 In a granted state with mem_done=1, SHALL pulse the granted side's done combinationally in the same cycle, return to IDLE at the next edge, and update the last-grant register.
REQ-012 ibus_input and dbus_input SHALL pass mem_rdata through while their done is high, and be 0 otherwise.
REQ-013 SHALL ignore mem_done in IDLE and SHALL never pass a done pulse to the non-granted side.
REQ-014 SHALL keep requests ignored in IDLE held pending; they are granted no later than the second IDLE cycle after the competing access, with no starvation under DBUS_PRIO=0.
REQ-015 SHALL keep an 8-bit wait counter that clears on grant and increments each granted cycle without mem_done.
REQ-016 When the wait counter reaches TIMEOUT-1 without mem_done, SHALL in that same cycle:
- drop mem_rd/mem_wr at the next edge;
- pulse the granted done with data 0;
- pulse bus_err;
- latch err_addr with mem_addr;
- go to IDLE.
REQ-017 mem_done arriving in the timeout cycle SHALL win: normal completion, no bus_err.
REQ-018 Back-to-back accesses SHALL have exactly one IDLE cycle between a mem_done cycle and the next strobe assertion.
REQ-019 Requests dropped before done (protocol violation) SHALL NOT abort an access in flight; the access completes or times out and its done is discarded.

Reset
REQ-020 With reset=1 at a rising edge, SHALL go to IDLE and force mem_rd=mem_wr=0, ibus_done=dbus_done=0, bus_err=0, mem_addr=0, mem_wdata=0, err_addr=0, wait counter=0 and last-grant=IBUS from the next cycle.
REQ-021 Reset mid-access SHALL abandon the access with no done or bus_err pulse; requests still held after reset deasserts SHALL be arbitrated afresh.

Verification
REQ-022 Single fetch: ibus_rd=1, ibus_addr=0o00100, memory answers 3 cycles later with rdata=0x123456789ABC -> mem_rd high 3 cycles, ibus_done=1 with ibus_input=0x123456789ABC, then IDLE.
REQ-023 Tie under round-robin: ibus_rd and dbus_rd both held from reset release -> grants DBUS, IBUS, DBUS, IBUS in turn, with one IDLE cycle between grants.
REQ-024 Write plus fetch: dbus_wr=1, addr=0o77777, data=0xFFFF00000001, while ibus_rd=1 -> mem_wr with those values first, then mem_rd for the fetch; mem_wr and mem_rd never both high.
REQ-025 Timeout: TIMEOUT=8, memory never answers dbus_rd at 0o00042 -> dbus_done and bus_err pulse 8 cycles after strobe start, dbus_input=0, err_addr=0o00042.
REQ-026 Reset mid-access: reset asserted 2 cycles into an ibus access -> strobes low next cycle, no done pulse; ibus_rd still held re-grants 1 cycle after reset release.
REQ-027 Race: mem_done arrives in the same cycle the timeout would fire -> normal done, bus_err stays 0.

Source files
------------

// File: rtl/mesm6_memarb.sv
// Arbiter between the instruction fetch bus and the data bus onto one shared memory port.
// Arbitration is round-robin or dbus-priority. Stalled accesses are aborted with a bus error.
module mesm6_memarb #(
  parameter int DBUS_PRIO = 0,
  parameter int TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ibus_rd,
  input  logic [14:0] ibus_addr,
  output logic [47:0] ibus_input,
  output logic        ibus_done,
  input  logic        dbus_rd,
  input  logic        dbus_wr,
  input  logic [14:0] dbus_addr,
  input  logic [47:0] dbus_output,
  output logic [47:0] dbus_input,
  output logic        dbus_done,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [14:0] mem_addr,
  output logic [47:0] mem_wdata,
  input  logic [47:0] mem_rdata,
  input  logic        mem_done,
  output logic        bus_err,
  output logic [14:0] err_addr
);

  localparam logic       LP_PRIO       = (DBUS_PRIO != 0);
  localparam logic [7:0] LP_WAIT_LIMIT = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_IBUS, S_DBUS} state_t;

  state_t      r_state;
  logic        r_mem_rd;
  logic        r_mem_wr;
  logic [14:0] r_mem_addr;
  logic [47:0] r_mem_wdata;
  logic [14:0] r_err_addr;
  logic [7:0]  r_wait;
  logic        r_last_dbus;

  logic w_ireq;
  logic w_dreq;
  logic w_granted;
  logic w_at_limit;
  logic w_finish;
  logic w_timeout;
  logic w_pick_dbus;

  assign w_ireq     = ibus_rd;
  assign w_dreq     = dbus_rd | dbus_wr;
  assign w_granted  = (r_state == S_IBUS) || (r_state == S_DBUS);
  assign w_at_limit = (r_wait == LP_WAIT_LIMIT);
  // A reset cycle abandons the access silently: no done, no error.
  assign w_finish   = w_granted & (mem_done | w_at_limit) & ~reset;
  assign w_timeout  = w_granted & ~mem_done & w_at_limit & ~reset;
  // On a tie, dbus wins under priority mode or when ibus held the last grant.
  assign w_pick_dbus = w_dreq & (~w_ireq | LP_PRIO | ~r_last_dbus);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_err_addr  <= '0;
      r_wait      <= '0;
      r_last_dbus <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ireq | w_dreq) begin
            r_state     <= w_pick_dbus ? S_DBUS : S_IBUS;
            r_mem_addr  <= w_pick_dbus ? dbus_addr : ibus_addr;
            r_mem_wdata <= dbus_output;
            r_mem_wr    <= w_pick_dbus & dbus_wr;
            r_mem_rd    <= ~(w_pick_dbus & dbus_wr);
            r_wait      <= '0;
          end
        end
        S_IBUS, S_DBUS: begin
          if (w_finish) begin
            r_state     <= S_IDLE;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_last_dbus <= (r_state == S_DBUS);
            if (w_timeout) r_err_addr <= r_mem_addr;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_mem_rd <= 1'b0;
          r_mem_wr <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd    = r_mem_rd;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign err_addr  = r_err_addr;
  assign bus_err   = w_timeout;

  assign ibus_done  = w_finish & (r_state == S_IBUS);
  assign dbus_done  = w_finish & (r_state == S_DBUS);
  // Read data is only forwarded on a real completion; a timeout returns zero.
  assign ibus_input = (ibus_done & mem_done) ? mem_rdata : '0;
  assign dbus_input = (dbus_done & mem_done) ? mem_rdata : '0;

endmodule
